// File: rtl/render_sequencer.sv
// render_sequencer: scanline/frame pulse sequencer with edge-buffer swap; RENDER_SEQ_OVERRUN_COUNT_EN enables overrun tally
module render_sequencer #(
  parameter int LINE_TRIGGER_X = 640,
  parameter int V_VISIBLE = 480,
  parameter int V_TOTAL = 525
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  raster_x,
  input  logic [9:0]  raster_y,
  input  logic        swap_req,
  input  logic [10:0] write_edge_count,
  input  logic        draw_done,
  output logic        frame_step,
  output logic        line_step,
  output logic        swap_commit,
  output logic [10:0] frame_edge_count,
  output logic        swap_pending,
  output logic        overrun,
  output logic [7:0]  overrun_count
);
  typedef enum logic [1:0] {IDLE, FRAME, DRAW, WAIT} state_t;
  state_t state;
  logic [9:0] prev_x;
  logic [10:0] pending_count;
  logic e, is_last, is_vis, from_wait, commit_go, overrun_go;
  assign e = raster_x == 10'(LINE_TRIGGER_X) && prev_x != 10'(LINE_TRIGGER_X);
  assign is_last = raster_y == 10'(V_TOTAL - 1);
  assign is_vis = raster_y <= 10'(V_VISIBLE - 2);
  assign from_wait = state == WAIT || (state == DRAW && draw_done);
  assign commit_go = e && is_last && (state == IDLE || from_wait);
  assign overrun_go = e && state == DRAW && !draw_done;
  // sequencer FSM, registered pulses and swap bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prev_x <= 10'(LINE_TRIGGER_X);
      frame_step <= 1'b0;
      line_step <= 1'b0;
      swap_commit <= 1'b0;
      overrun <= 1'b0;
      swap_pending <= 1'b0;
      pending_count <= '0;
      frame_edge_count <= '0;
    end else begin
      prev_x <= raster_x;
      frame_step <= commit_go;
      swap_commit <= commit_go && swap_pending;
      line_step <= state == FRAME || (e && from_wait && is_vis && !is_last);
      overrun <= overrun_go;
      if (commit_go) state <= FRAME;
      else if (state == FRAME) state <= DRAW;
      else if (from_wait) state <= !e ? WAIT : is_vis ? DRAW : IDLE;
      if (commit_go && swap_pending) frame_edge_count <= pending_count;
      if (swap_req) begin
        pending_count <= write_edge_count;
        swap_pending <= 1'b1;
      end else if (commit_go) swap_pending <= 1'b0;
    end
  end
`ifdef RENDER_SEQ_OVERRUN_COUNT_EN
  // saturating overrun tally, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) overrun_count <= '0;
    else if (overrun_go && overrun_count != 8'hff) overrun_count <= overrun_count + 8'd1;
  end
`else
  assign overrun_count = '0;
`endif
endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: randomized raster stimulus checked against a per-line behavioural model
module tb_render_sequencer;
  localparam int LT = 640;
  localparam int VV = 480;
  localparam int VT = 525;
  logic clk = 1'b0;
  logic rst;
  logic [9:0] raster_x, raster_y;
  logic swap_req, draw_done;
  logic [10:0] write_edge_count;
  logic frame_step, line_step, swap_commit, swap_pending, overrun;
  logic [10:0] frame_edge_count;
  logic [7:0] overrun_count;
  int errors = 0;
  int checks = 0;
  int dd_mode;
  int m_prev_x;
  bit m_synced, m_owed, m_line_next, m_pend;
  int m_count, m_fec, m_ovc;
  bit x_fs, x_ls, x_sc, x_ov;

  render_sequencer #(.LINE_TRIGGER_X(LT), .V_VISIBLE(VV), .V_TOTAL(VT)) dut (
    .clk(clk), .rst(rst), .raster_x(raster_x), .raster_y(raster_y),
    .swap_req(swap_req), .write_edge_count(write_edge_count), .draw_done(draw_done),
    .frame_step(frame_step), .line_step(line_step), .swap_commit(swap_commit),
    .frame_edge_count(frame_edge_count), .swap_pending(swap_pending),
    .overrun(overrun), .overrun_count(overrun_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  // One clock of the reference: what the outputs must be after this edge.
  task automatic model_step();
    bit e;
    e = int'(raster_x) == LT && m_prev_x != LT;
    m_prev_x = int'(raster_x);
    {x_fs, x_ls, x_sc, x_ov} = 4'b0;
    if (rst) begin
      m_prev_x = LT;
      {m_synced, m_owed, m_line_next, m_pend} = 4'b0;
      m_count = 0;
      m_fec = 0;
      m_ovc = 0;
      return;
    end
    if (m_line_next) begin
      x_ls = 1;
      m_owed = 1;
      m_line_next = 0;
    end else begin
      if (m_owed && draw_done) m_owed = 0;
      if (e) begin
        if (m_owed) begin
          x_ov = 1;
`ifdef RENDER_SEQ_OVERRUN_COUNT_EN
          if (m_ovc < 255) m_ovc++;
`endif
        end else if (int'(raster_y) == VT - 1) begin
          x_fs = 1;
          x_sc = m_pend;
          if (m_pend) m_fec = m_count;
          m_pend = 0;
          m_line_next = 1;
          m_synced = 1;
        end else if (m_synced) begin
          if (int'(raster_y) <= VV - 2) begin
            x_ls = 1;
            m_owed = 1;
          end else m_synced = 0;
        end
      end
    end
    if (swap_req) begin
      m_pend = 1;
      m_count = int'(write_edge_count);
    end
  endtask

  task automatic cyc(input logic [9:0] x, input logic r, input logic s);
    raster_x = x;
    rst = r;
    swap_req = s | ($urandom_range(0, 39) == 0);
    write_edge_count = 11'($urandom);
    draw_done = (dd_mode != 0) && ($urandom_range(0, 3) == 0);
    @(posedge clk);
    model_step();
    #1;
    check("pulses", {28'd0, frame_step, line_step, swap_commit, overrun}, {28'd0, x_fs, x_ls, x_sc, x_ov});
    check("swap_pending", {31'd0, swap_pending}, {31'd0, m_pend});
    check("frame_edge_count", {21'd0, frame_edge_count}, 32'(m_fec));
    check("overrun_count", {24'd0, overrun_count}, 32'(m_ovc));
  endtask

  initial begin
    raster_y = '0;
    dd_mode = 1;
    cyc(10'd0, 1'b1, 1'b0);
    cyc(10'd0, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) begin
      dd_mode = (f == 1) ? 0 : 1;
      for (int y = 0; y < VT; y++) begin
        raster_y = 10'(y);
        for (int i = 0; i < 2 + int'($urandom_range(0, 2)); i++) cyc(10'($urandom_range(0, LT - 1)), 1'b0, 1'b0);
        cyc(10'(LT), 1'b0, f == 0 && y == VT - 1);
        if ($urandom_range(0, 1) == 1) cyc(10'(LT), 1'b0, 1'b0);
        cyc(10'(LT + 1), 1'b0, 1'b0);
        cyc(10'(LT + 2), f == 2 && y == 100, 1'b0);
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
